// File: rtl/multicycle_ctrl_v2_pkg.sv
// Shared opcode map, controller state encoding and memory-state helper.
// Imported by the controller and its wait timer users.
package ctrl_v2_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MVR = 4'h1;
    localparam logic [3:0] OP_ADR = 4'h2;
    localparam logic [3:0] OP_ANR = 4'h3;
    localparam logic [3:0] OP_ORR = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LDA = 4'h6;
    localparam logic [3:0] OP_STA = 4'h7;
    localparam logic [3:0] OP_ADA = 4'h8;
    localparam logic [3:0] OP_ANA = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hB;

    typedef enum logic [3:0] {
        ST_IF,
        ST_DEC,
        ST_LDI,
        ST_MVR,
        ST_RTYPE,
        ST_ALU_TO_RF,
        ST_IF2,
        ST_JMP,
        ST_STA,
        ST_LD_MEM,
        ST_LDA,
        ST_MEM_TO_ALU,
        ST_ALU_TO_RF_D,
        ST_HALT
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_IF) || (s == ST_IF2) || (s == ST_LD_MEM) || (s == ST_STA);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access waits for mem_ready; timeout pulses combinationally on the
// MEM_TIMEOUT-th consecutive waiting cycle (0 disables). Counter clears on ready, timeout or inactivity.
module mem_wait_timer #(
    parameter int CNT_W       = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (cnt_q == LIMIT);
        cnt_d   = (active && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle CPU controller: opcode decode, multi-byte address fetch, memory wait/timeout, HALT.
// Strobes are combinational from state (JMP load is Mealy on jump_take); memory states stall on mem_ready.
module multicycle_ctrl_v2
    import ctrl_v2_pkg::*;
#(
    parameter int ADDR_BYTES  = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            instruction,
    input  logic                  jump_take,
    input  logic                  mem_ready,
    input  logic                  resume,
    output logic                  ld_PC,
    output logic                  ld_IR,
    output logic                  ld_DI,
    output logic                  ld_ALU,
    output logic                  write_en_rf,
    output logic                  sel_IR_3_2,
    output logic                  sel_DI_4_3,
    output logic                  sel_RF_write_src_TR_7_0,
    output logic                  sel_RF_write_src_ALU,
    output logic                  sel_RF_write_src_reg1,
    output logic                  sel_MEM_src_PC,
    output logic                  sel_MEM_src_TR,
    output logic                  sel_ALU_src_reg1,
    output logic                  sel_ALU_src_TR,
    output logic                  sel_PC_src_jump,
    output logic                  ld_CZN,
    output logic                  sel_CZN_src_RF,
    output logic                  sel_CZN_src_ALU,
    output logic [ADDR_BYTES-1:0] ld_TR,
    output logic                  MEM_read,
    output logic                  MEM_write,
    output logic                  halted,
    output logic                  illegal_op,
    output logic                  bus_err,
    output logic [3:0]            state_o
);

    localparam int IDX_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_BYTES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout;
    logic [ADDR_BYTES-1:0] tr_sel;

    mem_wait_timer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .rst       (rst),
        .active    (is_mem_state(state_q)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        for (int k = 0; k < ADDR_BYTES; k++) begin
            tr_sel[k] = (idx_q == IDX_W'(k));
        end
    end

    always_comb begin
        state_d                 = state_q;
        idx_d                   = idx_q;
        illegal_d               = illegal_q;
        bus_err_d               = bus_err_q;
        ld_PC                   = 1'b0;
        ld_IR                   = 1'b0;
        ld_DI                   = 1'b0;
        ld_ALU                  = 1'b0;
        write_en_rf             = 1'b0;
        sel_IR_3_2              = 1'b0;
        sel_DI_4_3              = 1'b0;
        sel_RF_write_src_TR_7_0 = 1'b0;
        sel_RF_write_src_ALU    = 1'b0;
        sel_RF_write_src_reg1   = 1'b0;
        sel_MEM_src_PC          = 1'b0;
        sel_MEM_src_TR          = 1'b0;
        sel_ALU_src_reg1        = 1'b0;
        sel_ALU_src_TR          = 1'b0;
        sel_PC_src_jump         = 1'b0;
        ld_CZN                  = 1'b0;
        sel_CZN_src_RF          = 1'b0;
        sel_CZN_src_ALU         = 1'b0;
        ld_TR                   = '0;
        MEM_read                = 1'b0;
        MEM_write               = 1'b0;
        halted                  = 1'b0;

        // Memory states: loads only fire on the mem_ready cycle; a timeout aborts to HALT.
        if (is_mem_state(state_q) && !mem_ready && timeout) begin
            state_d   = ST_HALT;
            bus_err_d = 1'b1;
        end

        case (state_q)
            ST_IF: begin
                sel_MEM_src_PC = 1'b1;
                MEM_read       = 1'b1;
                if (mem_ready) begin
                    ld_IR   = 1'b1;
                    ld_PC   = 1'b1;
                    state_d = ST_DEC;
                end
            end
            ST_DEC: begin
                idx_d = '0;
                case (instruction)
                    OP_NOP:                 state_d = ST_IF;
                    OP_LDI:                 state_d = ST_LDI;
                    OP_MVR:                 state_d = ST_MVR;
                    OP_ADR, OP_ANR, OP_ORR: state_d = ST_RTYPE;
                    OP_LDA, OP_STA, OP_ADA,
                    OP_ANA, OP_JMP:         state_d = ST_IF2;
                    OP_HLT:                 state_d = ST_HALT;
                    default: begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_LDI: begin
                ld_DI   = 1'b1;
                state_d = ST_IF;
            end
            ST_MVR: begin
                sel_RF_write_src_reg1 = 1'b1;
                write_en_rf           = 1'b1;
                sel_IR_3_2            = 1'b1;
                state_d               = ST_IF;
            end
            ST_RTYPE: begin
                sel_IR_3_2       = 1'b1;
                ld_ALU           = 1'b1;
                sel_ALU_src_reg1 = 1'b1;
                ld_CZN           = 1'b1;
                sel_CZN_src_ALU  = 1'b1;
                state_d          = ST_ALU_TO_RF;
            end
            ST_ALU_TO_RF: begin
                sel_RF_write_src_ALU = 1'b1;
                write_en_rf          = 1'b1;
                state_d              = ST_IF;
            end
            ST_IF2: begin
                sel_MEM_src_PC = 1'b1;
                MEM_read       = 1'b1;
                if (mem_ready) begin
                    ld_TR = tr_sel;
                    ld_PC = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (instruction == OP_JMP) begin
                        state_d = ST_JMP;
                    end else if (instruction == OP_STA) begin
                        state_d = ST_STA;
                    end else begin
                        state_d = ST_LD_MEM;
                    end
                end
            end
            ST_JMP: begin
                ld_PC           = jump_take;
                sel_PC_src_jump = jump_take;
                state_d         = ST_IF;
            end
            ST_STA: begin
                sel_DI_4_3     = 1'b1;
                sel_MEM_src_TR = 1'b1;
                MEM_write      = 1'b1;
                if (mem_ready) begin
                    state_d = ST_IF;
                end
            end
            ST_LD_MEM: begin
                sel_MEM_src_TR = 1'b1;
                MEM_read       = 1'b1;
                if (mem_ready) begin
                    ld_TR[0] = 1'b1;
                    state_d  = (instruction == OP_LDA) ? ST_LDA : ST_MEM_TO_ALU;
                end
            end
            ST_LDA: begin
                sel_DI_4_3              = 1'b1;
                sel_RF_write_src_TR_7_0 = 1'b1;
                write_en_rf             = 1'b1;
                ld_CZN                  = 1'b1;
                sel_CZN_src_RF          = 1'b1;
                state_d                 = ST_IF;
            end
            ST_MEM_TO_ALU: begin
                sel_ALU_src_TR  = 1'b1;
                sel_DI_4_3      = 1'b1;
                ld_ALU          = 1'b1;
                ld_CZN          = 1'b1;
                sel_CZN_src_ALU = 1'b1;
                state_d         = ST_ALU_TO_RF_D;
            end
            ST_ALU_TO_RF_D: begin
                sel_RF_write_src_ALU = 1'b1;
                sel_DI_4_3           = 1'b1;
                write_en_rf          = 1'b1;
                state_d              = ST_IF;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d   = ST_IF;
                    illegal_d = 1'b0;
                    bus_err_d = 1'b0;
                end
            end
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IF;
            idx_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal_op = illegal_q;
    assign bus_err    = bus_err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2 (ADDR_BYTES=2, MEM_TIMEOUT=4): per-cycle state, strobe and flag checks.
module tb_multicycle_ctrl_v2;

    localparam logic [3:0] S_IF = 4'd0, S_DEC = 4'd1, S_LDI = 4'd2, S_MVR = 4'd3, S_RTYPE = 4'd4;
    localparam logic [3:0] S_ATR = 4'd5, S_IF2 = 4'd6, S_JMP = 4'd7, S_STA = 4'd8, S_LDM = 4'd9;
    localparam logic [3:0] S_LDA = 4'd10, S_MTA = 4'd11, S_ATRD = 4'd12, S_HALT = 4'd13;

    // Strobe vector bit positions (MSB first): see the strb assignment below.
    localparam logic [21:0] M_PC    = 22'h200000;
    localparam logic [21:0] M_IR    = 22'h100000;
    localparam logic [21:0] M_DI    = 22'h080000;
    localparam logic [21:0] M_ALU   = 22'h040000;
    localparam logic [21:0] M_WE    = 22'h020000;
    localparam logic [21:0] M_SIR   = 22'h010000;
    localparam logic [21:0] M_SDI   = 22'h008000;
    localparam logic [21:0] M_RFTR  = 22'h004000;
    localparam logic [21:0] M_RFALU = 22'h002000;
    localparam logic [21:0] M_RFR1  = 22'h001000;
    localparam logic [21:0] M_MPC   = 22'h000800;
    localparam logic [21:0] M_MTR   = 22'h000400;
    localparam logic [21:0] M_AR1   = 22'h000200;
    localparam logic [21:0] M_ATR   = 22'h000100;
    localparam logic [21:0] M_PCJ   = 22'h000080;
    localparam logic [21:0] M_CZN   = 22'h000040;
    localparam logic [21:0] M_CRF   = 22'h000020;
    localparam logic [21:0] M_CALU  = 22'h000010;
    localparam logic [21:0] M_TR1   = 22'h000008;
    localparam logic [21:0] M_TR0   = 22'h000004;
    localparam logic [21:0] M_RD    = 22'h000002;
    localparam logic [21:0] M_WR    = 22'h000001;

    localparam logic [21:0] E_NONE  = 22'h0;
    localparam logic [21:0] E_IF    = M_MPC | M_RD | M_IR | M_PC;
    localparam logic [21:0] E_IFW   = M_MPC | M_RD;
    localparam logic [21:0] E_IF2A  = M_MPC | M_RD | M_TR0 | M_PC;
    localparam logic [21:0] E_IF2B  = M_MPC | M_RD | M_TR1 | M_PC;
    localparam logic [21:0] E_RTYPE = M_SIR | M_ALU | M_AR1 | M_CZN | M_CALU;
    localparam logic [21:0] E_ATR   = M_RFALU | M_WE;
    localparam logic [21:0] E_STA   = M_SDI | M_MTR | M_WR;

    logic clk = 1'b0;
    logic rst, jump_take, mem_ready, resume;
    logic [3:0] instruction;
    logic ld_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, sel_IR_3_2, sel_DI_4_3;
    logic sel_RF_write_src_TR_7_0, sel_RF_write_src_ALU, sel_RF_write_src_reg1;
    logic sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1, sel_ALU_src_TR, sel_PC_src_jump;
    logic ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU, MEM_read, MEM_write;
    logic halted, illegal_op, bus_err;
    logic [1:0] ld_TR;
    logic [3:0] state_o;
    logic [21:0] strb;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_v2 #(.ADDR_BYTES(2), .MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .jump_take(jump_take),
        .mem_ready(mem_ready), .resume(resume),
        .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_DI(ld_DI), .ld_ALU(ld_ALU), .write_en_rf(write_en_rf),
        .sel_IR_3_2(sel_IR_3_2), .sel_DI_4_3(sel_DI_4_3),
        .sel_RF_write_src_TR_7_0(sel_RF_write_src_TR_7_0), .sel_RF_write_src_ALU(sel_RF_write_src_ALU),
        .sel_RF_write_src_reg1(sel_RF_write_src_reg1),
        .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR),
        .sel_ALU_src_reg1(sel_ALU_src_reg1), .sel_ALU_src_TR(sel_ALU_src_TR),
        .sel_PC_src_jump(sel_PC_src_jump),
        .ld_CZN(ld_CZN), .sel_CZN_src_RF(sel_CZN_src_RF), .sel_CZN_src_ALU(sel_CZN_src_ALU),
        .ld_TR(ld_TR), .MEM_read(MEM_read), .MEM_write(MEM_write),
        .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
    );

    assign strb = {ld_PC, ld_IR, ld_DI, ld_ALU, write_en_rf, sel_IR_3_2, sel_DI_4_3,
                   sel_RF_write_src_TR_7_0, sel_RF_write_src_ALU, sel_RF_write_src_reg1,
                   sel_MEM_src_PC, sel_MEM_src_TR, sel_ALU_src_reg1, sel_ALU_src_TR,
                   sel_PC_src_jump, ld_CZN, sel_CZN_src_RF, sel_CZN_src_ALU,
                   ld_TR[1], ld_TR[0], MEM_read, MEM_write};
    assign flags = {halted, illegal_op, bus_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; checks this cycle, then moves one cycle on.
    task automatic step(input string tag, input logic [3:0] es, input logic [21:0] ex,
                        input logic [2:0] ef);
        #1;
        chk({tag, "/state"}, 32'(state_o), 32'(es));
        chk({tag, "/strobes"}, 32'(strb), 32'(ex));
        chk({tag, "/flags"}, 32'(flags), 32'(ef));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; instruction = 4'h0; jump_take = 1'b0; mem_ready = 1'b1; resume = 1'b0;
        @(negedge clk);
        step("reset", S_IF, E_IF, 3'b000);
        rst = 1'b0;

        // NOP with resume asserted outside HALT: must be ignored
        resume = 1'b1;
        step("nop_if", S_IF, E_IF, 3'b000);
        step("nop_dec", S_DEC, E_NONE, 3'b000);
        resume = 1'b0;

        instruction = 4'h5;
        step("ldi_if", S_IF, E_IF, 3'b000);
        step("ldi_dec", S_DEC, E_NONE, 3'b000);
        step("ldi", S_LDI, M_DI, 3'b000);

        instruction = 4'h1;
        step("mvr_if", S_IF, E_IF, 3'b000);
        step("mvr_dec", S_DEC, E_NONE, 3'b000);
        step("mvr", S_MVR, M_RFR1 | M_WE | M_SIR, 3'b000);

        instruction = 4'h4;
        step("orr_if", S_IF, E_IF, 3'b000);
        step("orr_dec", S_DEC, E_NONE, 3'b000);
        step("orr_rtype", S_RTYPE, E_RTYPE, 3'b000);
        step("orr_atr", S_ATR, E_ATR, 3'b000);

        // LDA: 6 cycles, TR bytes loaded 01 then 10
        instruction = 4'h6;
        step("lda_if", S_IF, E_IF, 3'b000);
        step("lda_dec", S_DEC, E_NONE, 3'b000);
        step("lda_if2a", S_IF2, E_IF2A, 3'b000);
        step("lda_if2b", S_IF2, E_IF2B, 3'b000);
        step("lda_ldm", S_LDM, M_MTR | M_RD | M_TR0, 3'b000);
        step("lda_wb", S_LDA, M_SDI | M_RFTR | M_WE | M_CZN | M_CRF, 3'b000);

        instruction = 4'h9;
        step("ana_if", S_IF, E_IF, 3'b000);
        step("ana_dec", S_DEC, E_NONE, 3'b000);
        step("ana_if2a", S_IF2, E_IF2A, 3'b000);
        step("ana_if2b", S_IF2, E_IF2B, 3'b000);
        step("ana_ldm", S_LDM, M_MTR | M_RD | M_TR0, 3'b000);
        step("ana_mta", S_MTA, M_ATR | M_SDI | M_ALU | M_CZN | M_CALU, 3'b000);
        step("ana_atrd", S_ATRD, M_RFALU | M_SDI | M_WE, 3'b000);

        instruction = 4'h7;
        step("sta_if", S_IF, E_IF, 3'b000);
        step("sta_dec", S_DEC, E_NONE, 3'b000);
        step("sta_if2a", S_IF2, E_IF2A, 3'b000);
        step("sta_if2b", S_IF2, E_IF2B, 3'b000);
        step("sta", S_STA, E_STA, 3'b000);

        // JMP not taken, then taken
        instruction = 4'hA;
        for (int t = 0; t < 2; t++) begin
            jump_take = 1'b0;
            step("jmp_if", S_IF, E_IF, 3'b000);
            step("jmp_dec", S_DEC, E_NONE, 3'b000);
            step("jmp_if2a", S_IF2, E_IF2A, 3'b000);
            step("jmp_if2b", S_IF2, E_IF2B, 3'b000);
            jump_take = (t == 1);
            step(t == 1 ? "jmp_taken" : "jmp_not", S_JMP, (t == 1) ? (M_PC | M_PCJ) : E_NONE, 3'b000);
        end
        jump_take = 1'b0;

        // IF with three wait cycles before mem_ready
        instruction = 4'h0;
        mem_ready = 1'b0;
        for (int w = 0; w < 3; w++) step("if_wait", S_IF, E_IFW, 3'b000);
        mem_ready = 1'b1;
        step("if_ready", S_IF, E_IF, 3'b000);
        step("if_wait_dec", S_DEC, E_NONE, 3'b000);

        // STA with mem_ready stuck low: timeout after 4 wait cycles
        instruction = 4'h7;
        step("sto_if", S_IF, E_IF, 3'b000);
        step("sto_dec", S_DEC, E_NONE, 3'b000);
        step("sto_if2a", S_IF2, E_IF2A, 3'b000);
        step("sto_if2b", S_IF2, E_IF2B, 3'b000);
        mem_ready = 1'b0;
        for (int w = 0; w < 4; w++) step("sto_wait", S_STA, E_STA, 3'b000);
        step("sto_halt", S_HALT, E_NONE, 3'b101);
        step("sto_halt2", S_HALT, E_NONE, 3'b101);
        mem_ready = 1'b1;
        resume = 1'b1;
        instruction = 4'hD;
        step("sto_resume", S_HALT, E_NONE, 3'b101);
        resume = 1'b0;

        // Illegal opcode, recovered by reset
        step("ill_if", S_IF, E_IF, 3'b000);
        step("ill_dec", S_DEC, E_NONE, 3'b000);
        step("ill_halt", S_HALT, E_NONE, 3'b110);
        rst = 1'b1;
        #1;
        chk("ill_rst/state", 32'(state_o), 32'(S_IF));
        chk("ill_rst/flags", 32'(flags), 32'(3'b000));
        @(negedge clk);
        rst = 1'b0;

        // HLT, recovered by resume
        instruction = 4'hB;
        step("hlt_if", S_IF, E_IF, 3'b000);
        step("hlt_dec", S_DEC, E_NONE, 3'b000);
        step("hlt_halt", S_HALT, E_NONE, 3'b100);
        resume = 1'b1;
        step("hlt_resume", S_HALT, E_NONE, 3'b100);
        resume = 1'b0;

        // Reset pulse in the middle of an R-type
        instruction = 4'h2;
        step("rtr_if", S_IF, E_IF, 3'b000);
        step("rtr_dec", S_DEC, E_NONE, 3'b000);
        #1;
        chk("rtr_mid/state", 32'(state_o), 32'(S_RTYPE));
        rst = 1'b1;
        #1;
        chk("rtr_rst/state", 32'(state_o), 32'(S_IF));
        chk("rtr_rst/strobes", 32'(strb), 32'(E_IF));
        chk("rtr_rst/flags", 32'(flags), 32'(3'b000));
        @(negedge clk);
        rst = 1'b0;
        step("rtr_after_if", S_IF, E_IF, 3'b000);
        step("rtr_after_dec", S_DEC, E_NONE, 3'b000);
        step("rtr_after_rtype", S_RTYPE, E_RTYPE, 3'b000);
        step("rtr_after_atr", S_ATR, E_ATR, 3'b000);
        step("end_if", S_IF, E_IF, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
